axi_ctrl_rr: RTL and testbench

Parametrised successor to the core's single-outstanding AXI master bridge. It arbitrates NUM_PORTS SRAM-style requesters with a round-robin policy. Each request becomes one AXI transaction: a single-beat write, or a read of up to MAX_LEN+1 beats using INCR bursts. Each requester gets its own accept, beat, done and error handshake; there is no global stall.

---
 rtl/axi_ctrl_rr_if.sv | 87 ++++++++
 rtl/axi_ctrl_rr.sv | 209 ++++++++++++++++++++
 tb/tb_axi_ctrl_rr.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ctrl_rr_if.sv
// AXI4 master-side bus bundle for axi_ctrl_rr: AW, W, B, AR and R channels plus
// the sideband fields the bridge ties to zero.
`timescale 1ns/1ps
interface axi_ctrl_rr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  // A beat transfers on every rising edge where valid and ready are both high;
  // the source holds valid and payload stable until that edge, and ready may
  // be driven without waiting for valid.
  logic                  core_axi_aw_valid_o;
  logic [ADDR_W-1:0]     core_axi_aw_addr_o;
  logic [ID_W-1:0]       core_axi_aw_id_o;
  logic [7:0]            core_axi_aw_len_o;
  logic [2:0]            core_axi_aw_size_o;
  logic [1:0]            core_axi_aw_burst_o;
  logic [2:0]            core_axi_aw_prot_o;
  logic [3:0]            core_axi_aw_cache_o;
  logic                  core_axi_aw_lock_o;
  logic [3:0]            core_axi_aw_qos_o;
  logic                  core_axi_aw_ready_i;

  logic                  core_axi_w_valid_o;
  logic [DATA_W-1:0]     core_axi_w_data_o;
  logic [DATA_W/8-1:0]   core_axi_w_strb_o;
  logic                  core_axi_w_last_o;
  logic                  core_axi_w_ready_i;

  logic                  core_axi_b_ready_o;
  logic                  core_axi_b_valid_i;
  logic [1:0]            core_axi_b_resp_i;
  logic [ID_W-1:0]       core_axi_b_id_i;

  logic                  core_axi_ar_valid_o;
  logic [ADDR_W-1:0]     core_axi_ar_addr_o;
  logic [ID_W-1:0]       core_axi_ar_id_o;
  logic [7:0]            core_axi_ar_len_o;
  logic [2:0]            core_axi_ar_size_o;
  logic [1:0]            core_axi_ar_burst_o;
  logic [2:0]            core_axi_ar_prot_o;
  logic [3:0]            core_axi_ar_cache_o;
  logic                  core_axi_ar_lock_o;
  logic [3:0]            core_axi_ar_qos_o;
  logic                  core_axi_ar_ready_i;

  logic                  core_axi_r_ready_o;
  logic                  core_axi_r_valid_i;
  logic [DATA_W-1:0]     core_axi_r_data_i;
  logic [1:0]            core_axi_r_resp_i;
  logic                  core_axi_r_last_i;
  logic [ID_W-1:0]       core_axi_r_id_i;

  modport master (
    output core_axi_aw_valid_o, core_axi_aw_addr_o, core_axi_aw_id_o, core_axi_aw_len_o,
           core_axi_aw_size_o, core_axi_aw_burst_o, core_axi_aw_prot_o, core_axi_aw_cache_o,
           core_axi_aw_lock_o, core_axi_aw_qos_o,
           core_axi_w_valid_o, core_axi_w_data_o, core_axi_w_strb_o, core_axi_w_last_o,
           core_axi_b_ready_o,
           core_axi_ar_valid_o, core_axi_ar_addr_o, core_axi_ar_id_o, core_axi_ar_len_o,
           core_axi_ar_size_o, core_axi_ar_burst_o, core_axi_ar_prot_o, core_axi_ar_cache_o,
           core_axi_ar_lock_o, core_axi_ar_qos_o,
           core_axi_r_ready_o,
    input  core_axi_aw_ready_i, core_axi_w_ready_i,
           core_axi_b_valid_i, core_axi_b_resp_i, core_axi_b_id_i,
           core_axi_ar_ready_i,
           core_axi_r_valid_i, core_axi_r_data_i, core_axi_r_resp_i, core_axi_r_last_i,
           core_axi_r_id_i
  );

  modport slave (
    input  core_axi_aw_valid_o, core_axi_aw_addr_o, core_axi_aw_id_o, core_axi_aw_len_o,
           core_axi_aw_size_o, core_axi_aw_burst_o, core_axi_aw_prot_o, core_axi_aw_cache_o,
           core_axi_aw_lock_o, core_axi_aw_qos_o,
           core_axi_w_valid_o, core_axi_w_data_o, core_axi_w_strb_o, core_axi_w_last_o,
           core_axi_b_ready_o,
           core_axi_ar_valid_o, core_axi_ar_addr_o, core_axi_ar_id_o, core_axi_ar_len_o,
           core_axi_ar_size_o, core_axi_ar_burst_o, core_axi_ar_prot_o, core_axi_ar_cache_o,
           core_axi_ar_lock_o, core_axi_ar_qos_o,
           core_axi_r_ready_o,
    output core_axi_aw_ready_i, core_axi_w_ready_i,
           core_axi_b_valid_i, core_axi_b_resp_i, core_axi_b_id_i,
           core_axi_ar_ready_i,
           core_axi_r_valid_i, core_axi_r_data_i, core_axi_r_resp_i, core_axi_r_last_i,
           core_axi_r_id_i
  );
endinterface

// File: rtl/axi_ctrl_rr.sv
// Round-robin bridge from NUM_PORTS SRAM-style requesters to one AXI4 master;
// one transaction in flight, single-beat writes, INCR reads of up to MAX_LEN+1 beats.
`timescale 1ns/1ps
module axi_ctrl_rr #(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int ID_BASE        = 1,
  parameter int MAX_LEN        = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  port_req,
  input  logic [NUM_PORTS*(AXI_DATA_WIDTH/8)-1:0] port_we,
  input  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0]   port_addr,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]   port_wdata,
  input  logic [NUM_PORTS*8-1:0]                port_len,
  output logic [NUM_PORTS-1:0]                  port_ack,
  output logic [NUM_PORTS-1:0]                  port_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]                  port_done,
  output logic [NUM_PORTS-1:0]                  port_err,
  output logic [2:0]                            dbg_state,
  axi_ctrl_rr_if.master                         axi
);
  localparam int STRB = AXI_DATA_WIDTH / 8;
  localparam int SIZE = $clog2(STRB);
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4,
    DONE         = 3'd5
  } state_t;

  state_t                 state;
  logic [PW-1:0]          ptr;
  logic [NUM_PORTS-1:0]   gnt_oh_q;
  logic                   err_q;

  logic                   gnt_vld;
  logic [PW-1:0]          gnt;
  logic [PW-1:0]          ptr_nxt;
  logic [NUM_PORTS-1:0]   gnt_oh;
  logic [STRB-1:0]        sel_we;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [AXI_DATA_WIDTH-1:0] sel_wdata;
  logic [7:0]             sel_len;
  logic [7:0]             sel_len_clamped;
  logic [AXI_ID_WIDTH-1:0] sel_id;

  // Scan from the pointer upward with wrap; the first requester found wins.
  always_comb begin : grant_sel
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_vld && port_req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = PW'(idx);
      end
    end
  end

  always_comb begin
    gnt_oh          = NUM_PORTS'(1) << gnt;
    ptr_nxt         = (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + PW'(1);
    sel_we          = port_we[int'(gnt)*STRB +: STRB];
    sel_addr        = port_addr[int'(gnt)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    sel_wdata       = port_wdata[int'(gnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    sel_len         = port_len[int'(gnt)*8 +: 8];
    sel_len_clamped = (sel_len > MAX_LEN_B) ? MAX_LEN_B : sel_len;
    sel_id          = AXI_ID_WIDTH'(ID_BASE + int'(gnt));
  end

  assign dbg_state = state;

  assign axi.core_axi_aw_prot_o  = '0;
  assign axi.core_axi_aw_cache_o = '0;
  assign axi.core_axi_aw_lock_o  = 1'b0;
  assign axi.core_axi_aw_qos_o   = '0;
  assign axi.core_axi_ar_prot_o  = '0;
  assign axi.core_axi_ar_cache_o = '0;
  assign axi.core_axi_ar_lock_o  = 1'b0;
  assign axi.core_axi_ar_qos_o   = '0;

  // Response IDs are ignored: with one transaction in flight they carry no information.
  logic unused_resp_ids;
  assign unused_resp_ids = ^{axi.core_axi_r_id_i, axi.core_axi_b_id_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      ptr                     <= '0;
      gnt_oh_q                <= '0;
      err_q                   <= 1'b0;
      port_ack                <= '0;
      port_rvalid             <= '0;
      port_rdata              <= '0;
      port_done               <= '0;
      port_err                <= '0;
      axi.core_axi_aw_valid_o <= 1'b0;
      axi.core_axi_aw_addr_o  <= '0;
      axi.core_axi_aw_id_o    <= '0;
      axi.core_axi_aw_len_o   <= '0;
      axi.core_axi_aw_size_o  <= '0;
      axi.core_axi_aw_burst_o <= '0;
      axi.core_axi_w_valid_o  <= 1'b0;
      axi.core_axi_w_data_o   <= '0;
      axi.core_axi_w_strb_o   <= '0;
      axi.core_axi_w_last_o   <= 1'b0;
      axi.core_axi_b_ready_o  <= 1'b0;
      axi.core_axi_ar_valid_o <= 1'b0;
      axi.core_axi_ar_addr_o  <= '0;
      axi.core_axi_ar_id_o    <= '0;
      axi.core_axi_ar_len_o   <= '0;
      axi.core_axi_ar_size_o  <= '0;
      axi.core_axi_ar_burst_o <= '0;
      axi.core_axi_r_ready_o  <= 1'b0;
    end else begin
      port_ack    <= '0;
      port_rvalid <= '0;
      port_done   <= '0;
      port_err    <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            gnt_oh_q <= gnt_oh;
            ptr      <= ptr_nxt;
            port_ack <= gnt_oh;
            err_q    <= 1'b0;
            if (|sel_we) begin
              axi.core_axi_aw_valid_o <= 1'b1;
              axi.core_axi_aw_addr_o  <= sel_addr & ALIGN_MASK;
              axi.core_axi_aw_id_o    <= sel_id;
              axi.core_axi_aw_len_o   <= 8'd0;
              axi.core_axi_aw_size_o  <= 3'(SIZE);
              axi.core_axi_aw_burst_o <= 2'b01;
              axi.core_axi_w_valid_o  <= 1'b1;
              axi.core_axi_w_data_o   <= sel_wdata;
              axi.core_axi_w_strb_o   <= sel_we;
              axi.core_axi_w_last_o   <= 1'b1;
              state                   <= WR_ADDR_DATA;
            end else begin
              axi.core_axi_ar_valid_o <= 1'b1;
              axi.core_axi_ar_addr_o  <= sel_addr & ALIGN_MASK;
              axi.core_axi_ar_id_o    <= sel_id;
              axi.core_axi_ar_len_o   <= sel_len_clamped;
              axi.core_axi_ar_size_o  <= 3'(SIZE);
              axi.core_axi_ar_burst_o <= 2'b01;
              state                   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi.core_axi_ar_ready_i) begin
            axi.core_axi_ar_valid_o <= 1'b0;
            axi.core_axi_r_ready_o  <= 1'b1;
            state                   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.core_axi_r_valid_i) begin
            port_rvalid <= gnt_oh_q;
            port_rdata  <= axi.core_axi_r_data_i;
            err_q       <= err_q | (axi.core_axi_r_resp_i != 2'b00);
            if (axi.core_axi_r_last_i) begin
              axi.core_axi_r_ready_o <= 1'b0;
              state                  <= DONE;
            end
          end
        end
        WR_ADDR_DATA: begin
          // AW and W complete independently; leave once neither is still pending.
          if (axi.core_axi_aw_valid_o && axi.core_axi_aw_ready_i) axi.core_axi_aw_valid_o <= 1'b0;
          if (axi.core_axi_w_valid_o && axi.core_axi_w_ready_i)   axi.core_axi_w_valid_o  <= 1'b0;
          if ((!axi.core_axi_aw_valid_o || axi.core_axi_aw_ready_i) &&
              (!axi.core_axi_w_valid_o  || axi.core_axi_w_ready_i)) begin
            axi.core_axi_b_ready_o <= 1'b1;
            state                  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.core_axi_b_valid_i) begin
            axi.core_axi_b_ready_o <= 1'b0;
            err_q                  <= (axi.core_axi_b_resp_i != 2'b00);
            state                  <= DONE;
          end
        end
        DONE: begin
          port_done <= gnt_oh_q;
          port_err  <= err_q ? gnt_oh_q : '0;
          err_q     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ctrl_rr.sv
// Bench for axi_ctrl_rr: directed requester/slave stimulus, expected responses
// queued at issue time and checked by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_axi_ctrl_rr;
  localparam int NP = 2, DW = 64, AW = 32, IW = 4, STRB = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]      port_req;
  logic [NP*STRB-1:0] port_we;
  logic [NP*AW-1:0]   port_addr;
  logic [NP*DW-1:0]   port_wdata;
  logic [NP*8-1:0]    port_len;
  logic [NP-1:0]      port_ack, port_rvalid, port_done, port_err;
  logic [DW-1:0]      port_rdata;
  logic [2:0]         dbg_state;

  axi_ctrl_rr_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();

  axi_ctrl_rr #(
    .NUM_PORTS(NP), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
    .AXI_ID_WIDTH(IW), .ID_BASE(1), .MAX_LEN(15)
  ) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_len(port_len),
    .port_ack(port_ack), .port_rvalid(port_rvalid), .port_rdata(port_rdata),
    .port_done(port_done), .port_err(port_err), .dbg_state(dbg_state),
    .axi(bus)
  );

  // scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  logic [1:0]  exp_ack_q[$];
  logic [48:0] exp_ar_q[$];   // {addr, id, len, size, burst}
  logic [48:0] exp_aw_q[$];
  logic [72:0] exp_w_q[$];    // {data, strb, last}
  logic [65:0] exp_rd_q[$];   // {rvalid vector, data}
  logic [3:0]  exp_done_q[$]; // {done vector, err vector}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (|port_ack) begin
        check("ack_expected", 128'(exp_ack_q.size() > 0), 128'(1));
        if (exp_ack_q.size() > 0) check("ack", 128'(port_ack), 128'(exp_ack_q.pop_front()));
      end
      if (bus.core_axi_ar_valid_o && bus.core_axi_ar_ready_i) begin
        check("ar_expected", 128'(exp_ar_q.size() > 0), 128'(1));
        if (exp_ar_q.size() > 0)
          check("ar_fields", 128'({bus.core_axi_ar_addr_o, bus.core_axi_ar_id_o, bus.core_axi_ar_len_o,
                                   bus.core_axi_ar_size_o, bus.core_axi_ar_burst_o}), 128'(exp_ar_q.pop_front()));
      end
      if (bus.core_axi_aw_valid_o && bus.core_axi_aw_ready_i) begin
        check("aw_expected", 128'(exp_aw_q.size() > 0), 128'(1));
        if (exp_aw_q.size() > 0)
          check("aw_fields", 128'({bus.core_axi_aw_addr_o, bus.core_axi_aw_id_o, bus.core_axi_aw_len_o,
                                   bus.core_axi_aw_size_o, bus.core_axi_aw_burst_o}), 128'(exp_aw_q.pop_front()));
      end
      if (bus.core_axi_w_valid_o && bus.core_axi_w_ready_i) begin
        check("w_expected", 128'(exp_w_q.size() > 0), 128'(1));
        if (exp_w_q.size() > 0)
          check("w_fields", 128'({bus.core_axi_w_data_o, bus.core_axi_w_strb_o, bus.core_axi_w_last_o}),
                128'(exp_w_q.pop_front()));
      end
      if (|port_rvalid) begin
        check("rvalid_expected", 128'(exp_rd_q.size() > 0), 128'(1));
        if (exp_rd_q.size() > 0) check("rbeat", 128'({port_rvalid, port_rdata}), 128'(exp_rd_q.pop_front()));
      end
      if (|port_done) begin
        check("done_expected", 128'(exp_done_q.size() > 0), 128'(1));
        if (exp_done_q.size() > 0) check("done_err", 128'({port_done, port_err}), 128'(exp_done_q.pop_front()));
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return |port_ack;
      1:       return bus.core_axi_r_ready_o;
      2:       return |port_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n;
    n = 0;
    while (!cond(which) && n < 200) begin
      tick();
      n++;
    end
    check(name, 128'(n < 200), 128'(1));
  endtask

  task automatic set_port(input int p, input logic [7:0] we, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [7:0] len);
    port_we[p*STRB +: STRB] = we;
    port_addr[p*AW +: AW]   = addr;
    port_wdata[p*DW +: DW]  = wdata;
    port_len[p*8 +: 8]      = len;
  endtask

  task automatic issue(input int p, input logic [7:0] we, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] len);
    set_port(p, we, addr, wdata, len);
    port_req[p] = 1'b1;
    wait_for(0, "wait_ack");
    port_req[p] = 1'b0;
  endtask

  // Slave read responder: gap_mask[b] inserts an idle cycle before beat b,
  // err_mask[b] answers beat b with SLVERR.
  task automatic slave_read(input int nbeats, input logic [63:0] base,
                            input logic [31:0] err_mask, input logic [31:0] gap_mask);
    wait_for(1, "wait_r_ready");
    for (int b = 0; b < nbeats; b++) begin
      if (gap_mask[b]) begin
        bus.core_axi_r_valid_i = 1'b0;
        tick();
      end
      bus.core_axi_r_valid_i = 1'b1;
      bus.core_axi_r_data_i  = base + 64'(b);
      bus.core_axi_r_resp_i  = err_mask[b] ? 2'b10 : 2'b00;
      bus.core_axi_r_last_i  = (b == nbeats - 1);
      tick();
    end
    bus.core_axi_r_valid_i = 1'b0;
    bus.core_axi_r_last_i  = 1'b0;
    bus.core_axi_r_resp_i  = 2'b00;
  endtask

  // Both ports requesting single-beat reads; req drops once the last ack is seen.
  task automatic rr_run(input int n, input logic [63:0] base);
    for (int k = 0; k < n; k++) begin
      wait_for(0, "wait_ack_rr");
      if (k == n - 1) port_req = '0;
      slave_read(1, base + 64'(k), 0, 0);
      wait_for(2, "wait_done_rr");
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; port_len = '0;
    bus.core_axi_aw_ready_i = 1'b0; bus.core_axi_w_ready_i = 1'b0;
    bus.core_axi_b_valid_i  = 1'b0; bus.core_axi_b_resp_i  = 2'b00; bus.core_axi_b_id_i = '0;
    bus.core_axi_ar_ready_i = 1'b0;
    bus.core_axi_r_valid_i  = 1'b0; bus.core_axi_r_data_i  = '0; bus.core_axi_r_resp_i = 2'b00;
    bus.core_axi_r_last_i   = 1'b0; bus.core_axi_r_id_i    = '0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_handshakes", 128'({port_ack, port_rvalid, port_done, port_err, bus.core_axi_ar_valid_o,
          bus.core_axi_aw_valid_o, bus.core_axi_w_valid_o, bus.core_axi_r_ready_o, bus.core_axi_b_ready_o}), 128'(0));
    check("rst_addr_id", 128'({bus.core_axi_ar_addr_o, bus.core_axi_aw_addr_o, bus.core_axi_ar_id_o,
          bus.core_axi_aw_id_o}), 128'(0));
    check("rst_data", 128'({bus.core_axi_w_data_o, port_rdata}), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    check("sideband_zero", 128'({bus.core_axi_aw_prot_o, bus.core_axi_aw_cache_o, bus.core_axi_aw_lock_o,
          bus.core_axi_aw_qos_o, bus.core_axi_ar_prot_o, bus.core_axi_ar_cache_o, bus.core_axi_ar_lock_o,
          bus.core_axi_ar_qos_o}), 128'(0));
    rst = 1'b0;
    tick();

    // single-beat read, port 0, unaligned address
    bus.core_axi_ar_ready_i = 1'b1;
    exp_ack_q.push_back(2'b01);
    exp_ar_q.push_back({32'h8000_0010, 4'd1, 8'd0, 3'd3, 2'd1});
    exp_rd_q.push_back({2'b01, 64'h1122_3344_5566_7788});
    exp_done_q.push_back({2'b01, 2'b00});
    issue(0, 8'h00, 32'h8000_0013, 64'h0, 8'd0);
    slave_read(1, 64'h1122_3344_5566_7788, 0, 0);
    wait_for(2, "wait_done_rd1");
    tick();

    // write, port 1, AW and W accepted on different cycles, SLVERR response
    exp_ack_q.push_back(2'b10);
    exp_aw_q.push_back({32'h0000_1008, 4'd2, 8'd0, 3'd3, 2'd1});
    exp_w_q.push_back({64'h0000_0000_0000_AABB, 8'h0F, 1'b1});
    exp_done_q.push_back({2'b10, 2'b10});
    issue(1, 8'h0F, 32'h0000_1008, 64'hAABB, 8'd0);
    check("wr_both_valid", 128'({bus.core_axi_aw_valid_o, bus.core_axi_w_valid_o}), 128'(2'b11));
    tick();
    bus.core_axi_aw_ready_i = 1'b1;
    tick();
    bus.core_axi_aw_ready_i = 1'b0;
    check("wr_aw_cleared_w_held", 128'({bus.core_axi_aw_valid_o, bus.core_axi_w_valid_o}), 128'(2'b01));
    tick();
    bus.core_axi_w_ready_i = 1'b1;
    tick();
    bus.core_axi_w_ready_i = 1'b0;
    check("wr_both_cleared", 128'({bus.core_axi_aw_valid_o, bus.core_axi_w_valid_o}), 128'(0));
    check("wr_b_ready", 128'(bus.core_axi_b_ready_o), 128'(1));
    bus.core_axi_b_valid_i = 1'b1;
    bus.core_axi_b_resp_i  = 2'b10;
    tick();
    bus.core_axi_b_valid_i = 1'b0;
    bus.core_axi_b_resp_i  = 2'b00;
    wait_for(2, "wait_done_wr");
    tick();

    // both ports requesting continuously: grants 0,1,0,1
    set_port(0, 8'h00, 32'h0000_0100, 64'h0, 8'd0);
    set_port(1, 8'h00, 32'h0000_0200, 64'h0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      exp_ack_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      exp_ar_q.push_back({(k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200, (k % 2 == 0) ? 4'd1 : 4'd2, 8'd0, 3'd3, 2'd1});
      exp_rd_q.push_back({(k % 2 == 0) ? 2'b01 : 2'b10, 64'hD0 + 64'(k)});
      exp_done_q.push_back({(k % 2 == 0) ? 2'b01 : 2'b10, 2'b00});
    end
    port_req = 2'b11;
    rr_run(4, 64'hD0);

    // 4-beat read with gaps and SLVERR on beat 2
    exp_ack_q.push_back(2'b01);
    exp_ar_q.push_back({32'h2000_0008, 4'd1, 8'd3, 3'd3, 2'd1});
    exp_rd_q.push_back({2'b01, 64'h0A00_0000_0000_0000});
    exp_rd_q.push_back({2'b01, 64'h0A00_0000_0000_0001});
    exp_rd_q.push_back({2'b01, 64'h0A00_0000_0000_0002});
    exp_rd_q.push_back({2'b01, 64'h0A00_0000_0000_0003});
    exp_done_q.push_back({2'b01, 2'b01});
    issue(0, 8'h00, 32'h2000_0008, 64'h0, 8'd3);
    slave_read(4, 64'h0A00_0000_0000_0000, 32'b0100, 32'b1010);
    wait_for(2, "wait_done_len3");
    tick();

    // len 20 clamped to 15: 16 beats
    exp_ack_q.push_back(2'b10);
    exp_ar_q.push_back({32'h3000_0000, 4'd2, 8'd15, 3'd3, 2'd1});
    for (int b = 0; b < 16; b++) exp_rd_q.push_back({2'b10, 64'h0B00_0000_0000_0000 + 64'(b)});
    exp_done_q.push_back({2'b10, 2'b00});
    issue(1, 8'h00, 32'h3000_0000, 64'h0, 8'd20);
    slave_read(16, 64'h0B00_0000_0000_0000, 0, 0);
    wait_for(2, "wait_done_len20");
    tick();

    // reset while in RD_DATA: no done, pointer back to 0
    exp_ack_q.push_back(2'b01);
    exp_ar_q.push_back({32'h0000_0400, 4'd1, 8'd1, 3'd3, 2'd1});
    exp_rd_q.push_back({2'b01, 64'hC0});
    issue(0, 8'h00, 32'h0000_0400, 64'h0, 8'd1);
    wait_for(1, "wait_r_ready_rst");
    bus.core_axi_r_valid_i = 1'b1;
    bus.core_axi_r_data_i  = 64'hC0;
    bus.core_axi_r_last_i  = 1'b0;
    tick();
    bus.core_axi_r_valid_i = 1'b0;
    check("mid_rd_state", 128'(dbg_state), 128'(2));
    rst = 1'b1;
    tick();
    check("rst_mid_handshakes", 128'({port_ack, port_rvalid, port_done, port_err, bus.core_axi_ar_valid_o,
          bus.core_axi_aw_valid_o, bus.core_axi_w_valid_o, bus.core_axi_r_ready_o, bus.core_axi_b_ready_o}), 128'(0));
    check("rst_mid_state", 128'(dbg_state), 128'(0));
    tick();
    rst = 1'b0;
    set_port(0, 8'h00, 32'h0000_0500, 64'h0, 8'd0);
    set_port(1, 8'h00, 32'h0000_0600, 64'h0, 8'd0);
    exp_ack_q.push_back(2'b01);
    exp_ack_q.push_back(2'b10);
    exp_ar_q.push_back({32'h0000_0500, 4'd1, 8'd0, 3'd3, 2'd1});
    exp_ar_q.push_back({32'h0000_0600, 4'd2, 8'd0, 3'd3, 2'd1});
    exp_rd_q.push_back({2'b01, 64'hE0});
    exp_rd_q.push_back({2'b10, 64'hE1});
    exp_done_q.push_back({2'b01, 2'b00});
    exp_done_q.push_back({2'b10, 2'b00});
    port_req = 2'b11;
    rr_run(2, 64'hE0);

    // final report
    repeat (3) tick();
    check("left_ack", 128'(exp_ack_q.size()), 128'(0));
    check("left_ar", 128'(exp_ar_q.size()), 128'(0));
    check("left_aw", 128'(exp_aw_q.size()), 128'(0));
    check("left_w", 128'(exp_w_q.size()), 128'(0));
    check("left_rd", 128'(exp_rd_q.size()), 128'(0));
    check("left_done", 128'(exp_done_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
